out_fifo_sync: RTL
==================

OUT_FIFO_SYNC -- requirements
Module: out_fifo_sync

Interface
REQ-001 Parameter ALMOST_EMPTY_VALUE, default 1, almost-empty threshold in entries; SHALL accept only 1 or 2.
REQ-002 Parameter ALMOST_FULL_VALUE, default 1, almost-full threshold in free entries; SHALL accept only 1 or 2.
REQ-003 Parameter ARRAY_MODE, default "ARRAY_MODE_8_X_4", read width mode; SHALL accept only "ARRAY_MODE_8_X_4" or "ARRAY_MODE_4_X_4".
REQ-004 Illegal parameter values SHALL print "Attribute Syntax Error" with instance path, then $finish, at time 0.
REQ-005 CLK  input  1  single clock for write and read sides.
REQ-006 RESET  input  1  reset, asynchronous, active-high.
REQ-007 WREN  input  1  write request, one entry per accepted cycle.
REQ-008 RDEN  input  1  read request, one read beat per accepted cycle.
REQ-009 D0..D9  input  8 each  write lanes; one entry = 80 bits.
REQ-010 Q0..Q4, Q7..Q9  output  4 each  nibble read lanes.
REQ-011 Q5, Q6  output  8 each  full-byte read lanes.
REQ-012 EMPTY, ALMOSTEMPTY, FULL, ALMOSTFULL  output  1 each  registered status flags.

Function
REQ-013 Storage SHALL be 8 entries x 80 bits, circular, 3-bit write/read pointers wrapping 7->0, 4-bit occupancy count 0..8.
REQ-014 Write SHALL be accepted on a CLK rising edge iff WREN=1 and FULL=0; WREN while FULL SHALL be ignored with no state change.
REQ-015 Read beat SHALL be accepted on a CLK rising edge iff RDEN=1 and EMPTY=0; RDEN while EMPTY SHALL be ignored, Q holds.
REQ-016 ARRAY_MODE_8_X_4: each entry SHALL take two read beats; phase 0 drives Dn[3:0] on 4-bit lanes, phase 1 drives Dn[7:4]; entry popped at end of phase 1.
REQ-017 ARRAY_MODE_4_X_4: each entry SHALL take one read beat driving Dn[3:0] on 4-bit lanes; phase stays 0.
REQ-018 Q5/Q6 SHALL carry the full D5/D6 byte of the entry on every beat of that entry.
REQ-019 Read latency: Q SHALL update on the accepting edge and be valid the following cycle; Q holds between beats.
REQ-020 Simultaneous accepted write and pop SHALL leave count unchanged; write while not full but pop same cycle SHALL both occur.
REQ-021 Write-to-read latency: an entry written into an empty FIFO SHALL clear EMPTY after that edge and be readable the next cycle.
REQ-022 EMPTY=1 iff count=0; FULL=1 iff count=8; flags SHALL be registered and reflect count after each edge.
REQ-023 ALMOSTEMPTY=1 iff count <= ALMOST_EMPTY_VALUE; ALMOSTFULL=1 iff count >= 8-ALMOST_FULL_VALUE.
REQ-024 In 8_X_4 mode a partially read entry (phase 1 pending) SHALL still count as occupied.

Reset
REQ-025 RESET=1 SHALL asynchronously clear pointers, count, phase and all Q to 0; EMPTY=1, ALMOSTEMPTY=1, FULL=0, ALMOSTFULL=0.
REQ-026 Reset mid-operation SHALL discard all stored entries and any pending phase; storage contents need not be cleared.
REQ-027 Operation SHALL resume on the first CLK rising edge after RESET falls.

Structure
REQ-028 Package out_fifo_sync_pkg SHALL hold DEPTH=8, PTR_W=3, CNT_W=4, ENTRY_W=80 and the array-mode constants.
REQ-029 One sub-module out_fifo_sync_mem (8x80 register array, one write port, one async read port) SHALL hold storage; pointer, phase and flag logic stay in the top.

Verification
REQ-030 Reset then 8 writes D0=8'hA5..(+1) -> FULL=1 and ALMOSTFULL=1 after 8th edge, ALMOSTFULL=1 after 7th; 9th write ignored.
REQ-031 8_X_4: write D0=8'h3C, D5=8'hE7, read twice -> Q0=4'hC then 4'h3, Q5=8'hE7 both beats, EMPTY=1 after second beat.
REQ-032 4_X_4: write 3 entries D0=8'h12,8'h34,8'h56, read 3 -> Q0=4'h2,4'h4,4'h6; ALMOSTEMPTY=1 at count 1 with ALMOST_EMPTY_VALUE=1.
REQ-033 Count=8, WREN=1 and RDEN=1 same edge (4_X_4) -> read taken, write ignored, count=7; at count=4 both -> count stays 4.
REQ-034 RESET pulse after 5 writes and 1 phase-0 read -> EMPTY=1, Q=0, next write/read returns new data at phase 0.
REQ-035 RDEN=1 while EMPTY=1 for 3 cycles -> Q unchanged, count stays 0, no pointer movement.

Source files
------------

// File: rtl/out_fifo_sync_pkg.sv
// Shared sizing, array-mode encodings and lane helpers for the 8-entry output FIFO.
package out_fifo_sync_pkg;

  localparam int DEPTH   = 8;
  localparam int PTR_W   = 3;
  localparam int CNT_W   = 4;
  localparam int LANE_W  = 8;
  localparam int NIB_W   = 4;
  localparam int LANES   = 10;
  localparam int ENTRY_W = LANES * LANE_W;

  // Array modes are 16-character strings carried as packed 128-bit values.
  localparam int MODE_W = 128;
  localparam logic [MODE_W-1:0] ARRAY_MODE_8_X_4 = "ARRAY_MODE_8_X_4";
  localparam logic [MODE_W-1:0] ARRAY_MODE_4_X_4 = "ARRAY_MODE_4_X_4";

  typedef enum logic {
    PH_LO = 1'b0,
    PH_HI = 1'b1
  } phase_e;

  function automatic logic threshold_ok(input int value);
    return (value == 1) || (value == 2);
  endfunction

  function automatic logic mode_ok(input logic [MODE_W-1:0] mode);
    return (mode == ARRAY_MODE_8_X_4) || (mode == ARRAY_MODE_4_X_4);
  endfunction

  function automatic logic [NIB_W-1:0] nibble_sel(input logic [LANE_W-1:0] lane,
                                                 input phase_e ph);
    return (ph == PH_HI) ? lane[LANE_W-1:NIB_W] : lane[NIB_W-1:0];
  endfunction

endpackage

// File: rtl/out_fifo_sync_mem.sv
// 8 x 80-bit register array: one synchronous write port, one asynchronous read port.
module out_fifo_sync_mem
  import out_fifo_sync_pkg::*;
(
  input  logic               clk,
  input  logic               we,
  input  logic [PTR_W-1:0]   waddr,
  input  logic [ENTRY_W-1:0] wdata,
  input  logic [PTR_W-1:0]   raddr,
  output logic [ENTRY_W-1:0] rdata
);

  logic [ENTRY_W-1:0] mem [DEPTH];

  // Contents are deliberately not reset; occupancy tracking makes stale data invisible.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/out_fifo_sync.sv
// Single-clock 8-entry FIFO taking 80-bit entries and reading them out as nibble
// lanes (one or two beats per entry) with full-byte lanes Q5/Q6.
module out_fifo_sync
  import out_fifo_sync_pkg::*;
#(
  parameter int                ALMOST_EMPTY_VALUE = 1,
  parameter int                ALMOST_FULL_VALUE  = 1,
  parameter logic [MODE_W-1:0] ARRAY_MODE         = ARRAY_MODE_8_X_4
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       WREN,
  input  logic       RDEN,
  input  logic [7:0] D0,
  input  logic [7:0] D1,
  input  logic [7:0] D2,
  input  logic [7:0] D3,
  input  logic [7:0] D4,
  input  logic [7:0] D5,
  input  logic [7:0] D6,
  input  logic [7:0] D7,
  input  logic [7:0] D8,
  input  logic [7:0] D9,
  output logic [3:0] Q0,
  output logic [3:0] Q1,
  output logic [3:0] Q2,
  output logic [3:0] Q3,
  output logic [3:0] Q4,
  output logic [7:0] Q5,
  output logic [7:0] Q6,
  output logic [3:0] Q7,
  output logic [3:0] Q8,
  output logic [3:0] Q9,
  output logic       EMPTY,
  output logic       ALMOSTEMPTY,
  output logic       FULL,
  output logic       ALMOSTFULL
);

  if (!(threshold_ok(ALMOST_EMPTY_VALUE) && threshold_ok(ALMOST_FULL_VALUE)
        && mode_ok(ARRAY_MODE))) begin : g_attr_check
    $fatal(1, "Attribute Syntax Error: %m has an illegal ALMOST_EMPTY_VALUE, ALMOST_FULL_VALUE or ARRAY_MODE");
  end

  localparam logic                TWO_BEAT   = (ARRAY_MODE == ARRAY_MODE_8_X_4);
  localparam logic [CNT_W-1:0]    AE_LEVEL   = CNT_W'(ALMOST_EMPTY_VALUE);
  localparam logic [CNT_W-1:0]    AF_LEVEL   = CNT_W'(DEPTH - ALMOST_FULL_VALUE);
  localparam logic [CNT_W-1:0]    FULL_LEVEL = CNT_W'(DEPTH);

  logic [PTR_W-1:0]   wr_ptr, wr_ptr_nxt;
  logic [PTR_W-1:0]   rd_ptr, rd_ptr_nxt;
  logic [CNT_W-1:0]   count, count_nxt;
  phase_e             phase, phase_nxt;
  logic               wr_acc, rd_acc, pop;
  logic [ENTRY_W-1:0] wdata, rdata;
  logic [LANE_W-1:0]  rd_lane [LANES];

  assign wdata = {D9, D8, D7, D6, D5, D4, D3, D2, D1, D0};

  out_fifo_sync_mem u_mem (
    .clk   (CLK),
    .we    (wr_acc),
    .waddr (wr_ptr),
    .wdata (wdata),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      rd_lane[i] = rdata[i*LANE_W +: LANE_W];
    end
  end

  // Next-state: acceptance is judged against the registered flags, so a write
  // offered while FULL is dropped even if a pop frees a slot on the same edge.
  always_comb begin
    wr_acc     = WREN && !FULL;
    rd_acc     = RDEN && !EMPTY;
    pop        = rd_acc && (!TWO_BEAT || (phase == PH_HI));
    wr_ptr_nxt = wr_ptr;
    rd_ptr_nxt = rd_ptr;
    count_nxt  = count;
    phase_nxt  = phase;
    if (wr_acc) begin
      wr_ptr_nxt = wr_ptr + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_nxt = rd_ptr + PTR_W'(1);
    end
    case ({wr_acc, pop})
      2'b10:   count_nxt = count + CNT_W'(1);
      2'b01:   count_nxt = count - CNT_W'(1);
      default: count_nxt = count;
    endcase
    if (rd_acc && TWO_BEAT) begin
      phase_nxt = (phase == PH_LO) ? PH_HI : PH_LO;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      phase       <= PH_LO;
      EMPTY       <= 1'b1;
      ALMOSTEMPTY <= 1'b1;
      FULL        <= 1'b0;
      ALMOSTFULL  <= 1'b0;
    end else begin
      wr_ptr      <= wr_ptr_nxt;
      rd_ptr      <= rd_ptr_nxt;
      count       <= count_nxt;
      phase       <= phase_nxt;
      EMPTY       <= (count_nxt == '0);
      ALMOSTEMPTY <= (count_nxt <= AE_LEVEL);
      FULL        <= (count_nxt == FULL_LEVEL);
      ALMOSTFULL  <= (count_nxt >= AF_LEVEL);
    end
  end

  // Read lanes load on each accepted beat and hold otherwise.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      Q0 <= '0;
      Q1 <= '0;
      Q2 <= '0;
      Q3 <= '0;
      Q4 <= '0;
      Q5 <= '0;
      Q6 <= '0;
      Q7 <= '0;
      Q8 <= '0;
      Q9 <= '0;
    end else if (rd_acc) begin
      Q0 <= nibble_sel(rd_lane[0], phase);
      Q1 <= nibble_sel(rd_lane[1], phase);
      Q2 <= nibble_sel(rd_lane[2], phase);
      Q3 <= nibble_sel(rd_lane[3], phase);
      Q4 <= nibble_sel(rd_lane[4], phase);
      Q5 <= rd_lane[5];
      Q6 <= rd_lane[6];
      Q7 <= nibble_sel(rd_lane[7], phase);
      Q8 <= nibble_sel(rd_lane[8], phase);
      Q9 <= nibble_sel(rd_lane[9], phase);
    end
  end

endmodule
